// File: rtl/writeback_arbiter_if.sv
//------------------------------------------------------------------------------
// writeback_arbiter_if
// Result-source handshakes and register-file write port of the write-back
// arbiter. The arbiter uses the slave modport; the result producers and the
// register-file side use the master modport.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface writeback_arbiter_if;
  // single-cycle ALU path
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  // long-latency memory/multiply path
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  // register-file write port and status
  logic        w_enabled;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        busy;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready,
    input  w_enabled, w_addr, w_data, busy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready,
    output w_enabled, w_addr, w_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/writeback_arbiter.sv
//------------------------------------------------------------------------------
// writeback_arbiter
// Merges the ALU result path (priority) and the FIFO-buffered memory path into
// one registered register-file write per cycle. A starvation counter stalls the
// ALU for one cycle to force a FIFO drain after STARVE_LIMIT blocked cycles.
// Optional build macro: WB_STATS_EN adds blocked_cnt / forced_cnt outputs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  writeback_arbiter_if.slave  bus
`ifdef WB_STATS_EN
  ,
  output logic [31:0]         blocked_cnt,
  output logic [31:0]         forced_cnt
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(DEPTH);
  localparam logic [c_STV_W-1:0] c_STV_LIMIT = c_STV_W'(STARVE_LIMIT);

  // FIFO storage and bookkeeping
  logic [4:0]         r_fifo_addr [DEPTH];
  logic [31:0]        r_fifo_data [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_STV_W-1:0] r_starve_cnt;

  // registered outputs
  logic        r_alu_ready;
  logic        r_w_enabled;
  logic [4:0]  r_w_addr;
  logic [31:0] r_w_data;
  logic        r_busy;

  // per-cycle decisions
  logic               w_alu_xfer;
  logic               w_alu_eff;
  logic               w_fifo_nonempty;
  logic               w_push;
  logic               w_pop;
  logic               w_blocked;
  logic               w_forced;
  logic [4:0]         w_head_addr;
  logic [31:0]        w_head_data;
  logic [c_CNT_W-1:0] w_count_next;
  logic [c_STV_W-1:0] w_starve_inc;

  assign bus.mem_ready = (r_count != c_FULL);
  assign bus.alu_ready = r_alu_ready;
  assign bus.w_enabled = r_w_enabled;
  assign bus.w_addr    = r_w_addr;
  assign bus.w_data    = r_w_data;
  assign bus.busy      = r_busy;

  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // Selection: an ALU write to a non-zero rd wins; otherwise the stored head
  // (never this cycle's push) retires. While alu_ready is low no ALU transfer
  // can happen, so the head pops unconditionally in that cycle.
  always_comb begin
    w_alu_xfer      = bus.alu_valid & r_alu_ready;
    w_alu_eff       = w_alu_xfer & (bus.alu_addr != 5'd0);
    w_fifo_nonempty = (r_count != '0);
    w_push          = bus.mem_valid & bus.mem_ready;
    w_pop           = ~w_alu_eff & w_fifo_nonempty;
    w_blocked       = w_alu_eff & w_fifo_nonempty;
    w_forced        = ~r_alu_ready;
    w_starve_inc    = r_starve_cnt + 1'b1;
    w_count_next    = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // FIFO payload storage; contents need no reset because count gates reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.mem_addr;
      r_fifo_data[r_wr_ptr] <= bus.mem_data;
    end
  end

  // FIFO pointers, occupancy and the registered busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_busy  <= (w_count_next != '0);
    end
  end

  // Starvation tracking: the ALU is stalled for exactly one cycle when the
  // blocked streak reaches the limit; the forced pop then clears the streak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_alu_ready  <= 1'b1;
    end else begin
      r_alu_ready <= 1'b1;
      if (w_pop) begin
        r_starve_cnt <= '0;
      end else if (w_blocked) begin
        r_starve_cnt <= w_starve_inc;
        if (w_starve_inc == c_STV_LIMIT) r_alu_ready <= 1'b0;
      end
    end
  end

  // Register-file write port; address/data hold when nothing is written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_enabled <= 1'b0;
      r_w_addr    <= 5'd0;
      r_w_data    <= 32'd0;
    end else begin
      r_w_enabled <= 1'b0;
      if (w_alu_eff) begin
        r_w_enabled <= 1'b1;
        r_w_addr    <= bus.alu_addr;
        r_w_data    <= bus.alu_data;
      end else if (w_pop && (w_head_addr != 5'd0)) begin
        r_w_enabled <= 1'b1;
        r_w_addr    <= w_head_addr;
        r_w_data    <= w_head_data;
      end
    end
  end

`ifdef WB_STATS_EN
  logic [31:0] r_blocked_cnt;
  logic [31:0] r_forced_cnt;

  assign blocked_cnt = r_blocked_cnt;
  assign forced_cnt  = r_forced_cnt;

  // Saturating event counters for blocked-head and forced-drain cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blocked_cnt <= 32'd0;
      r_forced_cnt  <= 32'd0;
    end else begin
      if (w_blocked && (r_blocked_cnt != 32'hFFFF_FFFF)) r_blocked_cnt <= r_blocked_cnt + 32'd1;
      if (w_forced  && (r_forced_cnt  != 32'hFFFF_FFFF)) r_forced_cnt  <= r_forced_cnt + 32'd1;
    end
  end
`else
  // statistics counters are not built; w_forced only feeds them
  logic w_unused_forced;
  assign w_unused_forced = w_forced;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
//------------------------------------------------------------------------------
// tb_writeback_arbiter
// Directed self-checking bench for writeback_arbiter (DEPTH=4, STARVE_LIMIT=8).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_writeback_arbiter;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  writeback_arbiter_if bus ();

`ifdef WB_STATS_EN
  logic [31:0] blocked_cnt;
  logic [31:0] forced_cnt;
`endif

  writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef WB_STATS_EN
    ,
    .blocked_cnt (blocked_cnt),
    .forced_cnt  (forced_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value against its expected value
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one cycle; sample point is 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_addr  = a;
    bus.alu_data  = d;
  endtask

  task automatic mem_drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.mem_valid = v;
    bus.mem_addr  = a;
    bus.mem_data  = d;
  endtask

  task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check_val({tag, ".we"},   32'(bus.w_enabled), 32'd1);
    check_val({tag, ".addr"}, 32'(bus.w_addr),    32'(a));
    check_val({tag, ".data"}, bus.w_data,         d);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    alu_drive(1'b0, 5'd0, 32'd0);
    mem_drive(1'b0, 5'd0, 32'd0);
    #1;

    // reset state
    check_val("rst.we",     32'(bus.w_enabled), 32'd0);
    check_val("rst.addr",   32'(bus.w_addr),    32'd0);
    check_val("rst.data",   bus.w_data,         32'd0);
    check_val("rst.aready", 32'(bus.alu_ready), 32'd1);
    check_val("rst.busy",   32'(bus.busy),      32'd0);
    check_val("rst.mready", 32'(bus.mem_ready), 32'd1);
    step();
    rst = 1'b0;
    step();

    // ALU only: one-cycle latency
    alu_drive(1'b1, 5'd5, 32'h1234);
    step();
    alu_drive(1'b0, 5'd0, 32'd0);
    check_write("alu", 5'd5, 32'h1234);
    check_val("alu.busy", 32'(bus.busy), 32'd0);
    step();
    check_val("alu.idle", 32'(bus.w_enabled), 32'd0);

    // memory only: two-cycle latency
    mem_drive(1'b1, 5'd7, 32'hDEADBEEF);
    step();
    mem_drive(1'b0, 5'd0, 32'd0);
    check_val("mem.busy1", 32'(bus.busy),      32'd1);
    check_val("mem.we1",   32'(bus.w_enabled), 32'd0);
    step();
    check_write("mem", 5'd7, 32'hDEADBEEF);
    check_val("mem.busy2", 32'(bus.busy), 32'd0);

    // fill to full while the ALU keeps the port busy
    for (int i = 0; i < 5; i++) begin
      alu_drive(1'b1, 5'd1, 32'h500 + 32'(i));
      mem_drive(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
      if (i == 4) check_val("full.mready", 32'(bus.mem_ready), 32'd0);
      step();
      check_write("full.alu", 5'd1, 32'h500 + 32'(i));
      if (i < 4) mem_drive(1'b0, 5'd0, 32'd0);
    end
    // 5th offer (addr 14) still held; release the ALU
    mem_drive(1'b1, 5'd14, 32'hA4);
    alu_drive(1'b0, 5'd0, 32'd0);
    check_val("full.mready2", 32'(bus.mem_ready), 32'd0);
    step();
    check_write("drain0", 5'd10, 32'hA0);
    check_val("drain.mready", 32'(bus.mem_ready), 32'd1);
    step();
    mem_drive(1'b0, 5'd0, 32'd0);
    for (int i = 1; i < 5; i++) begin
      check_write("drain", 5'(10 + i), 32'hA0 + 32'(i));
      if (i < 4) step();
    end
    step();
    check_val("drain.busy", 32'(bus.busy),      32'd0);
    check_val("drain.we",   32'(bus.w_enabled), 32'd0);

    // starvation: one entry queued, ALU writes every cycle
    alu_drive(1'b1, 5'd2, 32'h0FF);
    mem_drive(1'b1, 5'd20, 32'hF00D);
    step();
    mem_drive(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check_val("starve.aready", 32'(bus.alu_ready), 32'd1);
      alu_drive(1'b1, 5'd2, 32'h100 + 32'(i));
      step();
    end
    check_val("starve.stall", 32'(bus.alu_ready), 32'd0);
    check_write("starve.last", 5'd2, 32'h107);
    alu_drive(1'b1, 5'd2, 32'h108);
    step();
    check_write("starve.fifo", 5'd20, 32'hF00D);
    check_val("starve.aready2", 32'(bus.alu_ready), 32'd1);
    step();
    alu_drive(1'b0, 5'd0, 32'd0);
    check_write("starve.held", 5'd2, 32'h108);
`ifdef WB_STATS_EN
    check_val("stats.blocked", blocked_cnt, 32'd12);
    check_val("stats.forced",  forced_cnt,  32'd1);
`endif
    step();

    // ALU to x0 alongside a queued entry: head pops, no ALU write
    mem_drive(1'b1, 5'd3, 32'h33);
    step();
    mem_drive(1'b0, 5'd0, 32'd0);
    alu_drive(1'b1, 5'd0, 32'h55);
    step();
    alu_drive(1'b0, 5'd0, 32'd0);
    check_write("x0alu", 5'd3, 32'h33);
    check_val("x0alu.busy", 32'(bus.busy), 32'd0);

    // FIFO entry to x0: popped without a write
    mem_drive(1'b1, 5'd0, 32'h77);
    step();
    mem_drive(1'b0, 5'd0, 32'd0);
    check_val("x0mem.busy1", 32'(bus.busy), 32'd1);
    step();
    check_val("x0mem.we",    32'(bus.w_enabled), 32'd0);
    check_val("x0mem.busy2", 32'(bus.busy),      32'd0);

    // async reset with three queued entries and a write pending
    for (int i = 0; i < 3; i++) begin
      alu_drive(1'b1, 5'd4, 32'h40 + 32'(i));
      mem_drive(1'b1, 5'(24 + i), 32'hC0 + 32'(i));
      step();
    end
    alu_drive(1'b0, 5'd0, 32'd0);
    mem_drive(1'b0, 5'd0, 32'd0);
    check_val("ar.pre_we",   32'(bus.w_enabled), 32'd1);
    check_val("ar.pre_busy", 32'(bus.busy),      32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("ar.we",     32'(bus.w_enabled), 32'd0);
    check_val("ar.busy",   32'(bus.busy),      32'd0);
    check_val("ar.mready", 32'(bus.mem_ready), 32'd1);
    check_val("ar.aready", 32'(bus.alu_ready), 32'd1);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("ar.post_we",   32'(bus.w_enabled), 32'd0);
      check_val("ar.post_busy", 32'(bus.busy),      32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // hard time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Producer side of the register file's single write port: drives w_enabled/w_addr/w_data into the register file.
- Merges two result sources into one registered write per cycle:
  - the single-cycle ALU path, which has priority;
  - the long-latency memory/multiply path, which has a valid/ready handshake and is buffered in a small FIFO.
- A starvation counter guarantees that FIFO results eventually retire.

Parameters:
- DEPTH, 4, FIFO entries for the memory path; power of two, >= 2.
- STARVE_LIMIT, 8, consecutive blocked cycles before the ALU path is stalled for one forced FIFO drain; >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU result present this cycle.
- alu_ready  output  1  arbiter accepts ALU result; registered.
- alu_addr  input  5  destination register.
- alu_data  input  32  result value.
- mem_valid  input  1  memory-path result offered.
- mem_ready  output  1  FIFO can accept; combinational from count.
- mem_addr  input  5  destination register.
- mem_data  input  32  result value.
- w_enabled  output  1  register-file write strobe; registered.
- w_addr  output  5  register-file write address; registered.
- w_data  output  32  register-file write data; registered.
- busy  output  1  FIFO non-empty; registered.

Behaviour:
- Reset (async, immediate): w_enabled=0, w_addr=0, w_data=0, alu_ready=1, busy=0, FIFO empty (wr_ptr=rd_ptr=0, count=0), starve_cnt=0. mem_ready=1, since the FIFO is not full.
- Handshakes:
  - ALU transfer = alu_valid & alu_ready.
  - Memory push = mem_valid & mem_ready, where mem_ready = (count != DEPTH).
  - Producers hold addr/data stable while valid & !ready.
- Pop eligibility: only entries already stored at the start of the cycle may pop; there is no same-cycle bypass from mem_* to w_*.
- Per-cycle selection, with alu_eff = ALU transfer & (alu_addr != 0):
  - alu_eff: write ALU result; FIFO head blocked if count != 0.
  - ALU transfer with alu_addr == 0: result consumed, no write; FIFO head may pop this cycle.
  - No ALU write and count != 0: pop head; write it only if head addr != 0 (x0 entries are popped but produce w_enabled=0).
  - Otherwise: w_enabled=0. w_addr/w_data hold their previous values.
- Latency:
  - ALU: result offered in cycle t gives w_enabled high in cycle t+1.
  - Memory: accepted in cycle t, earliest write appears in cycle t+2.
- FIFO:
  - Circular buffer; pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push when full is impossible because mem_ready=0.
- Starvation:
  - starve_cnt increments in each cycle where the head is blocked by an ALU write.
  - starve_cnt clears to 0 on any pop.
  - When the incremented value equals STARVE_LIMIT, alu_ready is cleared at that edge.
  - In a cycle with alu_ready=0 the head pops unconditionally and alu_ready returns to 1 at the next edge. Any held ALU result then transfers.
  - alu_ready is therefore never low for two consecutive cycles.
- Ordering:
  - FIFO entries retire strictly in push order.
  - Upstream guarantees no outstanding WAW between the ALU and FIFO for the same rd; this block does not check for it.
- busy equals (count != 0), registered, so it reflects the post-edge count.
- Reset asserted mid-operation: FIFO contents are discarded, no write is issued, all outputs return to reset values asynchronously.

Optional Feature:
- Macro: WB_STATS_EN.
- Defined:
  - Adds output ports blocked_cnt (32 bits) and forced_cnt (32 bits), both reset to 0 and saturating at 0xFFFFFFFF.
  - blocked_cnt increments on each head-blocked cycle.
  - forced_cnt increments on each forced-drain cycle (alu_ready=0).
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- ALU only: alu_valid=1, addr=5, data=0x1234 in cycle 0 -> cycle 1 shows w_enabled=1, w_addr=5, w_data=0x1234; FIFO untouched, busy=0.
- Memory only: push addr=7, data=0xDEADBEEF in cycle 0 -> busy=1 in cycle 1; write of r7=0xDEADBEEF in cycle 2; busy=0 afterwards.
- Fill/full (DEPTH=4), ALU held busy:
  - 4 pushes, then mem_ready=0 and the 5th offer is held;
  - release ALU -> pops retire in push order at one per cycle;
  - mem_ready rises in the cycle after the first pop.
- Starvation (STARVE_LIMIT=8): one FIFO entry plus continuous ALU writes -> after 8 blocked cycles alu_ready=0 for exactly one cycle; FIFO entry written that cycle+1; held ALU result written the cycle after.
- x0 handling:
  - ALU addr=0 plus FIFO entry in the same cycle -> no ALU write, FIFO head pops;
  - FIFO entry with addr=0 -> popped with w_enabled=0.
- Async reset with 3 entries queued and a write pending -> w_enabled=0 immediately; busy=0, mem_ready=1, no stale write after reset release.
